// File: rtl/wave_detect_mr.sv
// Preamble/wave detector for the RFID reverse-link Rx path.
// Counts alternating rise/fall edges whose spacing falls in the half- or
// full-bit window of the latched link rate. It declares lock after
// LOCK_EDGES qualifying edges. Lock is dropped on an edge timeout, on
// coincident edge strobes, or on a synchronous restart.
module wave_detect_mr #(
    parameter int unsigned GAP_W         = 9,
    parameter int unsigned EDGE_CNT_W    = 5,
    parameter int unsigned LOCK_EDGES    = 12,
    parameter int unsigned TIMEOUT_SHIFT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic [2:0]            set_rate_i,
    input  logic                  restart_i,
    input  logic                  rise_valid_i,
    input  logic                  fall_valid_i,
    input  logic [GAP_W-1:0]      gap_point_i,
    output logic                  wave_enable_o,
    output logic                  lock_pulse_o,
    output logic                  loss_pulse_o,
    output logic [EDGE_CNT_W-1:0] edge_cnt_o
);

    localparam int unsigned TIMER_W = GAP_W + TIMEOUT_SHIFT + 1;
    localparam logic [TIMER_W-1:0]    TIMER_MAX = '1;
    localparam logic [EDGE_CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [EDGE_CNT_W-1:0] LOCK_CNT  = EDGE_CNT_W'(LOCK_EDGES);

    typedef struct packed {
        logic [GAP_W-1:0] half_small;
        logic [GAP_W-1:0] half_big;
        logic [GAP_W-1:0] full_small;
        logic [GAP_W-1:0] full_big;
    } win_t;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Build one window entry from integer thresholds.
    function automatic win_t mk_win(input int unsigned hs, input int unsigned hb,
                                    input int unsigned fs, input int unsigned fb);
        win_t w;
        w.half_small = GAP_W'(hs);
        w.half_big   = GAP_W'(hb);
        w.full_small = GAP_W'(fs);
        w.full_big   = GAP_W'(fb);
        return w;
    endfunction

    // Link-rate window table.
    function automatic win_t rate_lookup(input logic [2:0] rate);
        win_t w;
        w = mk_win(140, 258, 273, 507);
        case (rate)
            3'd0: w = mk_win(140, 258, 273, 507);
            3'd1: w = mk_win( 65, 120, 127, 236);
            3'd2: w = mk_win( 51,  95, 100, 186);
            3'd3: w = mk_win( 28,  52,  54, 101);
            3'd4: w = mk_win( 70, 129, 136, 253);
            3'd5: w = mk_win( 32,  60,  63, 118);
            3'd6: w = mk_win( 25,  47,  50,  93);
            3'd7: w = mk_win( 14,  26,  27,  50);
            default: w = mk_win(140, 258, 273, 507);
        endcase
        return w;
    endfunction

    state_t                state_q, state_d;
    win_t                  win_q, win_d;
    logic [EDGE_CNT_W-1:0] cnt_q, cnt_d;
    logic                  pol_q, pol_d;      // expected polarity, 1 = rise
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic                  wave_en_q, wave_en_d;
    logic                  lock_pulse_q, lock_pulse_d;
    logic                  loss_pulse_q, loss_pulse_d;

    logic                  edge_evt;
    logic                  edge_both;
    logic                  gap_ok;
    logic [TIMER_W-1:0]    timer_inc;
    logic [TIMER_W-1:0]    track_limit;
    logic [TIMER_W-1:0]    lock_limit;
    logic [EDGE_CNT_W-1:0] cnt_inc;

    // Edge decode, window qualification and timer helpers.
    always_comb begin
        edge_evt    = rise_valid_i ^ fall_valid_i;
        edge_both   = rise_valid_i & fall_valid_i;
        gap_ok      = ((gap_point_i >= win_q.half_small) && (gap_point_i <= win_q.half_big)) ||
                      ((gap_point_i >= win_q.full_small) && (gap_point_i <= win_q.full_big));
        timer_inc   = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_W'(1);
        track_limit = TIMER_W'(win_q.full_big);
        lock_limit  = TIMER_W'(win_q.full_big) << TIMEOUT_SHIFT;
        cnt_inc     = cnt_q + EDGE_CNT_W'(1);
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        cnt_d        = cnt_q;
        pol_d        = pol_q;
        timer_d      = timer_q;
        wave_en_d    = wave_en_q;
        lock_pulse_d = 1'b0;
        loss_pulse_d = 1'b0;

        if (state_q == ST_HUNT) begin
            win_d = rate_lookup(set_rate_i);
        end

        if (edge_evt || (state_q == ST_HUNT)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_inc;
        end

        if (restart_i) begin
            state_d   = ST_HUNT;
            win_d     = rate_lookup(set_rate_i);
            cnt_d     = '0;
            pol_d     = 1'b0;
            timer_d   = '0;
            wave_en_d = 1'b0;
        end else if (edge_both) begin
            state_d   = ST_HUNT;
            cnt_d     = '0;
            timer_d   = '0;
            wave_en_d = 1'b0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    wave_en_d = 1'b0;
                    if (edge_evt) begin
                        state_d = ST_TRACK;
                        cnt_d   = EDGE_CNT_W'(1);
                        pol_d   = ~rise_valid_i;
                    end
                end
                ST_TRACK: begin
                    if (edge_evt) begin
                        if ((rise_valid_i == pol_q) && gap_ok) begin
                            cnt_d = cnt_inc;
                            pol_d = ~pol_q;
                            if (cnt_inc == LOCK_CNT) begin
                                state_d      = ST_LOCKED;
                                wave_en_d    = 1'b1;
                                lock_pulse_d = 1'b1;
                            end
                        end else begin
                            cnt_d = EDGE_CNT_W'(1);
                            pol_d = ~rise_valid_i;
                        end
                    end else if (timer_inc >= track_limit) begin
                        state_d = ST_HUNT;
                        cnt_d   = '0;
                        timer_d = '0;
                    end
                end
                ST_LOCKED: begin
                    wave_en_d = 1'b1;
                    if (edge_evt) begin
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc;
                        pol_d = ~rise_valid_i;
                    end else if (timer_inc >= lock_limit) begin
                        state_d      = ST_HUNT;
                        cnt_d        = '0;
                        timer_d      = '0;
                        wave_en_d    = 1'b0;
                        loss_pulse_d = 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_HUNT;
                    cnt_d     = '0;
                    timer_d   = '0;
                    wave_en_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            win_q        <= rate_lookup(3'd0);
            cnt_q        <= '0;
            pol_q        <= 1'b0;
            timer_q      <= '0;
            wave_en_q    <= 1'b0;
            lock_pulse_q <= 1'b0;
            loss_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            pol_q        <= pol_d;
            timer_q      <= timer_d;
            wave_en_q    <= wave_en_d;
            lock_pulse_q <= lock_pulse_d;
            loss_pulse_q <= loss_pulse_d;
        end
    end

    assign wave_enable_o = wave_en_q;
    assign lock_pulse_o  = lock_pulse_q;
    assign loss_pulse_o  = loss_pulse_q;
    assign edge_cnt_o    = cnt_q;

endmodule

// File: tb/tb_wave_detect_mr.sv
// Directed bench for wave_detect_mr with an expected-output queue.
module tb_wave_detect_mr;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] set_rate_i = 3'd3;
    logic       restart_i = 1'b0;
    logic       rise_valid_i = 1'b0;
    logic       fall_valid_i = 1'b0;
    logic [8:0] gap_point_i = '0;
    logic       wave_enable_o;
    logic       lock_pulse_o;
    logic       loss_pulse_o;
    logic [4:0] edge_cnt_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int   cnt;
        logic en;
        logic lock;
        logic loss;
    } exp_t;

    exp_t sb[$];

    wave_detect_mr dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .set_rate_i   (set_rate_i),
        .restart_i    (restart_i),
        .rise_valid_i (rise_valid_i),
        .fall_valid_i (fall_valid_i),
        .gap_point_i  (gap_point_i),
        .wave_enable_o(wave_enable_o),
        .lock_pulse_o (lock_pulse_o),
        .loss_pulse_o (loss_pulse_o),
        .edge_cnt_o   (edge_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input int cnt, input logic en, input logic lk, input logic ls);
        exp_t e;
        e.cnt  = cnt;
        e.en   = en;
        e.lock = lk;
        e.loss = ls;
        sb.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_cnt"},  32'(edge_cnt_o),    32'(e.cnt));
            chk({tag, "_en"},   32'(wave_enable_o), 32'(e.en));
            chk({tag, "_lock"}, 32'(lock_pulse_o),  32'(e.lock));
            chk({tag, "_loss"}, 32'(loss_pulse_o),  32'(e.loss));
        end
    endtask

    // Idle cycle, then compare.
    task automatic step_check(input string tag, input int cnt, input logic en,
                              input logic lk, input logic ls);
        push_exp(cnt, en, lk, ls);
        @(negedge clk_i);
        compare_out(tag);
    endtask

    // One-cycle edge strobe (sampled at the next posedge), then compare.
    task automatic drive_edge(input string tag, input logic r, input logic f, input int gap,
                              input int cnt, input logic en, input logic lk);
        push_exp(cnt, en, lk, 1'b0);
        rise_valid_i = r;
        fall_valid_i = f;
        gap_point_i  = 9'(gap);
        @(negedge clk_i);
        rise_valid_i = 1'b0;
        fall_valid_i = 1'b0;
        gap_point_i  = '0;
        compare_out(tag);
    endtask

    task automatic do_restart(input string tag);
        push_exp(0, 1'b0, 1'b0, 1'b0);
        restart_i = 1'b1;
        @(negedge clk_i);
        restart_i = 1'b0;
        compare_out(tag);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Twelve alternating edges starting with a rise, reaching lock.
    task automatic lock_run(input string tag, input int gap);
        for (int i = 0; i < 12; i++) begin
            drive_edge(tag, (i % 2) == 0, (i % 2) != 0, gap, i + 1, i == 11, i == 11);
        end
    endtask

    initial begin
        // Reset state
        idle(2);
        push_exp(0, 1'b0, 1'b0, 1'b0);
        compare_out("reset");
        rst_n = 1'b1;
        step_check("post_reset", 0, 1'b0, 1'b0, 1'b0);

        // Test 1: rate 3, 12 edges at gap 40 lock
        lock_run("t1", 40);
        step_check("t1_hold", 12, 1'b1, 1'b0, 1'b0);

        // Locked edges are data; counter saturates at 31
        for (int k = 0; k < 22; k++) begin
            drive_edge("lk_sat", 1'b1, 1'b0, 5, (13 + k > 31) ? 31 : 13 + k, 1'b1, 1'b0);
        end

        // Test 4: resuming at 201 cycles keeps lock; loss at 202
        idle(200);
        drive_edge("t4_resume201", 1'b0, 1'b1, 5, 31, 1'b1, 1'b0);
        idle(200);
        step_check("t4_at201", 31, 1'b1, 1'b0, 1'b0);
        step_check("t4_at202", 0, 1'b0, 1'b0, 1'b1);
        step_check("t4_after", 0, 1'b0, 1'b0, 1'b0);

        // Test 2: between-window gap restarts count; lock at 18th edge
        do_restart("t2_rst");
        for (int i = 1; i <= 6; i++) begin
            drive_edge("t2_pre", (i % 2) == 1, (i % 2) == 0, 40, i, 1'b0, 1'b0);
        end
        drive_edge("t2_gap53", 1'b1, 1'b0, 53, 1, 1'b0, 1'b0);
        for (int i = 8; i <= 18; i++) begin
            drive_edge("t2_post", (i % 2) == 1, (i % 2) == 0, 80, i - 6, i == 18, i == 18);
        end
        step_check("t2_hold", 12, 1'b1, 1'b0, 1'b0);

        // Test 3: repeated rise restarts count
        do_restart("t3_rst");
        for (int i = 1; i <= 4; i++) begin
            drive_edge("t3_pre", (i % 2) == 0, (i % 2) == 1, 40, i, 1'b0, 1'b0);
        end
        drive_edge("t3_dup_rise", 1'b1, 1'b0, 40, 1, 1'b0, 1'b0);
        for (int i = 6; i <= 16; i++) begin
            drive_edge("t3_post", (i % 2) == 1, (i % 2) == 0, 40, i - 4, i == 16, i == 16);
        end
        // Coincident strobes while locked: drop without loss pulse
        drive_edge("t3_both_lk", 1'b1, 1'b1, 40, 0, 1'b0, 1'b0);
        // Coincident strobes while tracking
        drive_edge("t3_tr1", 1'b1, 1'b0, 5, 1, 1'b0, 1'b0);
        drive_edge("t3_tr2", 1'b0, 1'b1, 40, 2, 1'b0, 1'b0);
        drive_edge("t3_both_tr", 1'b1, 1'b1, 40, 0, 1'b0, 1'b0);
        drive_edge("t3_hunt", 1'b1, 1'b0, 5, 1, 1'b0, 1'b0);

        // Test 5: table frozen in TRACK, reloaded by restart
        set_rate_i = 3'd3;
        do_restart("t5_rst3");
        drive_edge("t5_r3_e1", 1'b1, 1'b0, 0, 1, 1'b0, 1'b0);
        set_rate_i = 3'd7;
        drive_edge("t5_r3_e2", 1'b0, 1'b1, 80, 2, 1'b0, 1'b0);
        drive_edge("t5_r3_e3", 1'b1, 1'b0, 20, 1, 1'b0, 1'b0);
        do_restart("t5_rst7");
        drive_edge("t5_r7_e1", 1'b1, 1'b0, 0, 1, 1'b0, 1'b0);
        drive_edge("t5_r7_e2", 1'b0, 1'b1, 20, 2, 1'b0, 1'b0);
        drive_edge("t5_r7_e3", 1'b1, 1'b0, 26, 3, 1'b0, 1'b0);
        drive_edge("t5_r7_e4", 1'b0, 1'b1, 80, 1, 1'b0, 1'b0);
        // TRACK timeout at rate 7 full_big = 50 cycles
        idle(48);
        step_check("t5_trk49", 1, 1'b0, 1'b0, 1'b0);
        step_check("t5_trk50", 0, 1'b0, 1'b0, 1'b0);

        // Test 6: async reset while locked
        set_rate_i = 3'd3;
        do_restart("t6_rst");
        lock_run("t6", 40);
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(0, 1'b0, 1'b0, 1'b0);
        compare_out("t6_async");
        @(negedge clk_i);
        rst_n = 1'b1;
        step_check("t6_released", 0, 1'b0, 1'b0, 1'b0);
        drive_edge("t6_hunt_edge", 1'b0, 1'b1, 300, 1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
